// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation request in, registered result and status out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [3:0]       OP;
  logic [WIDTH:0]   immediate;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] R_in;
  logic [WIDTH-1:0] OUT;
  logic             overflow_out;
  logic             busy;
  logic             done;
  logic             halted;

  // Requester side
  modport master (
    output start, OP, immediate, A_in, R_in,
    input  OUT, overflow_out, busy, done, halted
  );

  // ALU side
  modport slave (
    input  start, OP, immediate, A_in, R_in,
    output OUT, overflow_out, busy, done, halted
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with an IDLE/SHIFT/DONE controller, sticky halt and a carry register.
// Optional build macro ALU_SEQ_BARREL_EN: lsl/lsr use a single-cycle barrel shifter instead of
// the default one-bit-per-cycle serial shifter.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      CLK,
  input  logic      reset_n,
  alu_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    WidthCnt = CW'(WIDTH);
  localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

  localparam logic [3:0] OpGet   = 4'h0;
  localparam logic [3:0] OpSet   = 4'h1;
  localparam logic [3:0] OpLw    = 4'h2;
  localparam logic [3:0] OpSw    = 4'h3;
  localparam logic [3:0] OpAdd   = 4'h4;
  localparam logic [3:0] OpSub   = 4'h5;
  localparam logic [3:0] OpAnd   = 4'h6;
  localparam logic [3:0] OpBt    = 4'h7;
  localparam logic [3:0] OpBf    = 4'h8;
  localparam logic [3:0] OpEq    = 4'h9;
  localparam logic [3:0] OpLt    = 4'hA;
  localparam logic [3:0] OpXor   = 4'hB;
  localparam logic [3:0] OpParse = 4'hC;
  localparam logic [3:0] OpLsl   = 4'hD;
  localparam logic [3:0] OpLsr   = 4'hE;
  localparam logic [3:0] OpHalt  = 4'hF;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_halted, w_halted_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_dir, w_dir_nxt;  // 1: shift left

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_res_carry;
  logic [WIDTH-1:0] w_shifted;
  logic             w_is_shift;
  logic [CW-1:0]    w_amt;
`ifdef ALU_SEQ_BARREL_EN
  logic [WIDTH-1:0] w_barrel;
`endif

  assign w_is_shift = (bus.OP == OpLsl) || (bus.OP == OpLsr);
  // Shift count saturates at WIDTH; anything larger shifts everything out anyway
  assign w_amt      = (bus.R_in >= WidthVal) ? WidthCnt : CW'(bus.R_in);
  assign w_shifted  = r_dir ? (r_shreg << 1) : (r_shreg >> 1);

`ifdef ALU_SEQ_BARREL_EN
  // Single-cycle shifter used in place of the serial SHIFT state
  always_comb begin
    w_barrel = '0;
    if (bus.R_in < WidthVal) begin
      w_barrel = (bus.OP == OpLsl) ? (bus.A_in << bus.R_in) : (bus.A_in >> bus.R_in);
    end
  end
`endif

  // Single-cycle result for every non-shift opcode, computed from the live request inputs
  always_comb begin
    w_sum       = {1'b0, bus.A_in} + {1'b0, bus.R_in} + {{WIDTH{1'b0}}, r_carry};
    w_diff      = bus.A_in - bus.R_in;
    w_res       = r_out;
    w_res_carry = r_carry;
    unique case (bus.OP)
      OpGet, OpLw, OpSw: w_res = bus.R_in;
      OpSet, OpParse:    w_res = bus.A_in;
      OpAdd: begin
        w_res       = w_sum[WIDTH-1:0];
        w_res_carry = w_sum[WIDTH];
      end
      OpSub: w_res = w_diff;
      OpAnd: w_res = bus.A_in & bus.R_in;
      OpXor: w_res = bus.A_in ^ bus.R_in;
      OpBt:  w_res = (bus.A_in == WIDTH'(1)) ? bus.R_in : '0;
      OpBf:  w_res = (bus.A_in == '0) ? bus.R_in : '0;
      OpEq:  w_res = {{(WIDTH-1){1'b0}}, (w_diff == '0)};
      OpLt:  w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1]};
      OpLsl, OpLsr, OpHalt: w_res = r_out;
      default: w_res = r_out;
    endcase
  end

  // Controller next-state and datapath updates
  always_comb begin
    w_state_nxt  = r_state;
    w_out_nxt    = r_out;
    w_carry_nxt  = r_carry;
    w_halted_nxt = r_halted;
    w_cnt_nxt    = r_cnt;
    w_shreg_nxt  = r_shreg;
    w_dir_nxt    = r_dir;
    unique case (r_state)
      StIdle: begin
        if (bus.start && !r_halted) begin
          w_state_nxt = StDone;
          if (!bus.immediate[WIDTH]) begin
            // Immediate override wins over any opcode, including halt and shifts
            w_out_nxt = bus.immediate[WIDTH-1:0];
          end else if (w_is_shift) begin
`ifdef ALU_SEQ_BARREL_EN
            w_out_nxt = w_barrel;
`else
            if (w_amt == '0) begin
              w_out_nxt = bus.A_in;
            end else begin
              w_state_nxt = StShift;
              w_shreg_nxt = bus.A_in;
              w_cnt_nxt   = w_amt;
              w_dir_nxt   = (bus.OP == OpLsl);
            end
`endif
          end else begin
            w_out_nxt    = w_res;
            w_carry_nxt  = w_res_carry;
            w_halted_nxt = r_halted | (bus.OP == OpHalt);
          end
        end
      end
      StShift: begin
        w_shreg_nxt = w_shifted;
        w_cnt_nxt   = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_out_nxt   = w_shifted;
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_out    <= '0;
      r_carry  <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_dir    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_carry  <= w_carry_nxt;
      r_halted <= w_halted_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shreg  <= w_shreg_nxt;
      r_dir    <= w_dir_nxt;
    end
  end

  assign bus.OUT          = r_out;
  assign bus.overflow_out = r_carry;
  assign bus.busy         = (r_state != StIdle);
  assign bus.done         = (r_state == StDone);
  assign bus.halted       = r_halted;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: requests push expected results, a negedge monitor checks each done.
module tb_alu_seq;

  localparam logic [3:0] OpGet = 4'h0, OpSet = 4'h1, OpLw = 4'h2, OpSw = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4, OpSub = 4'h5, OpAnd = 4'h6, OpBt = 4'h7;
  localparam logic [3:0] OpBf = 4'h8, OpEq = 4'h9, OpLt = 4'hA, OpXor = 4'hB;
  localparam logic [3:0] OpParse = 4'hC, OpLsl = 4'hD, OpLsr = 4'hE, OpHalt = 4'hF;
  localparam logic [8:0] NoImm = 9'h100;

  typedef struct packed {
    logic [7:0] out;
    logic       c;
    logic       h;
  } exp_t;

  logic CLK = 1'b0;
  logic reset_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("OUT", 32'(bus.OUT), 32'(e.out));
        chk("overflow_out", 32'(bus.overflow_out), 32'(e.c));
        chk("halted", 32'(bus.halted), 32'(e.h));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [8:0] imm, input logic [7:0] a,
                       input logic [7:0] r, input logic [7:0] eo, input logic ec,
                       input logic eh, input int elat, input bit poke);
    exp_t e;
    int   lat;
    bit   seen;
    int   want;
    e.out = eo;
    e.c   = ec;
    e.h   = eh;
    want  = elat;
`ifdef ALU_SEQ_BARREL_EN
    if (imm[8] && (op == OpLsl || op == OpLsr)) want = 1;
`endif
    exp_q.push_back(e);
    @(negedge CLK);
    bus.start = 1'b1; bus.OP = op; bus.immediate = imm; bus.A_in = a; bus.R_in = r;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        // Post-latch input changes must not matter
        bus.start = 1'b0; bus.A_in = ~a; bus.R_in = ~r; bus.OP = OpXor;
      end
      if (poke && lat == 2) begin
        bus.start = 1'b1; bus.OP = OpGet; bus.immediate = NoImm;
      end
      if (poke && lat == 3) bus.start = 1'b0;
      chk("busy_during_op", 32'(bus.busy), 32'd1);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(want));
    @(negedge CLK);
    chk("done_single_pulse", 32'(bus.done), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.OP = OpGet; bus.immediate = NoImm; bus.A_in = '0; bus.R_in = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_OUT", 32'(bus.OUT), 32'h0);
    chk("rst_ovf", 32'(bus.overflow_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;

    //    op       imm    A      R      OUT    c     h     lat poke
    issue(OpAdd,   NoImm, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1, 0);
    issue(OpAdd,   NoImm, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1, 0);
    issue(OpLsl,   NoImm, 8'h01, 8'h03, 8'h08, 1'b0, 1'b0, 4, 0);
    issue(OpLsr,   NoImm, 8'h80, 8'h09, 8'h00, 1'b0, 1'b0, 9, 0);
    issue(OpLsr,   NoImm, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1, 0);
    issue(OpLt,    NoImm, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 1, 0);
    issue(OpLt,    NoImm, 8'h05, 8'h03, 8'h00, 1'b0, 1'b0, 1, 0);
    issue(OpEq,    NoImm, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1, 0);
    issue(OpEq,    NoImm, 8'h5A, 8'h5B, 8'h00, 1'b0, 1'b0, 1, 0);
    issue(OpAdd,   NoImm, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1, 0);
    issue(OpAdd,   9'h07F, 8'h12, 8'h34, 8'h7F, 1'b1, 1'b0, 1, 0);
    issue(OpSub,   NoImm, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1, 0);
    issue(OpAnd,   NoImm, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0, 1, 0);
    issue(OpXor,   NoImm, 8'hF0, 8'h3C, 8'hCC, 1'b1, 1'b0, 1, 0);
    issue(OpBt,    NoImm, 8'h01, 8'hAB, 8'hAB, 1'b1, 1'b0, 1, 0);
    issue(OpBt,    NoImm, 8'h02, 8'hAB, 8'h00, 1'b1, 1'b0, 1, 0);
    issue(OpBf,    NoImm, 8'h00, 8'hCD, 8'hCD, 1'b1, 1'b0, 1, 0);
    issue(OpBf,    NoImm, 8'h01, 8'hCD, 8'h00, 1'b1, 1'b0, 1, 0);
    issue(OpGet,   NoImm, 8'h99, 8'h11, 8'h11, 1'b1, 1'b0, 1, 0);
    issue(OpSet,   NoImm, 8'h22, 8'h99, 8'h22, 1'b1, 1'b0, 1, 0);
    issue(OpParse, NoImm, 8'h33, 8'h99, 8'h33, 1'b1, 1'b0, 1, 0);
    issue(OpLw,    NoImm, 8'h99, 8'h44, 8'h44, 1'b1, 1'b0, 1, 0);
    issue(OpSw,    NoImm, 8'h99, 8'h55, 8'h55, 1'b1, 1'b0, 1, 0);
    issue(OpLsl,   NoImm, 8'hFF, 8'h08, 8'h00, 1'b1, 1'b0, 9, 0);
    issue(OpAdd,   NoImm, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1, 0);
    issue(OpAdd,   NoImm, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 1, 0);
    issue(OpLsl,   NoImm, 8'h01, 8'h05, 8'h20, 1'b1, 1'b0, 6, 1);

`ifndef ALU_SEQ_BARREL_EN
    // Abort a serial shift with reset; no done may follow
    @(negedge CLK);
    bus.start = 1'b1; bus.OP = OpLsl; bus.immediate = NoImm; bus.A_in = 8'h01; bus.R_in = 8'h05;
    @(negedge CLK);
    bus.start = 1'b0;
    chk("shift_busy", 32'(bus.busy), 32'd1);
    @(negedge CLK);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_OUT", 32'(bus.OUT), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    chk("abort_ovf", 32'(bus.overflow_out), 32'h0);
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
`else
    @(negedge CLK);
    reset_n = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
`endif

    issue(OpAdd,   NoImm, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1, 0);
    issue(OpHalt,  NoImm, 8'h77, 8'h88, 8'h30, 1'b0, 1'b1, 1, 0);
    @(negedge CLK);
    bus.start = 1'b1; bus.OP = OpGet; bus.immediate = NoImm; bus.R_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("halted_no_done", 32'(bus.done), 32'd0);
      chk("halted_no_busy", 32'(bus.busy), 32'd0);
      chk("halted_OUT_held", 32'(bus.OUT), 32'h30);
    end
    bus.start = 1'b0;
    chk("halted_sticky", 32'(bus.halted), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("halt_cleared", 32'(bus.halted), 32'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
